// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: the fetch stage reads, and the program loader takes the write
// port in bursts. Define IMEM_ARB_FAIR_EN to force a one-cycle fetch window every MAX_BURST grants.
module imem_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic [15:0] f_rdata,
    output logic        f_valid,
    output logic        f_stall,
    output logic        f_flush,
    input  logic        l_req,
    output logic        l_gnt,
    input  logic        l_we,
    input  logic [15:0] l_addr,
    input  logic [15:0] l_data,
    output logic [15:0] mem_rdaddr,
    output logic [15:0] mem_wraddr,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    input  logic [15:0] mem_q
);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_f_valid;
    logic       w_accept;
    logic       w_force_release;
    logic       w_yield;
    logic       w_burst_done;

`ifdef IMEM_ARB_FAIR_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_yield;

    // r_cnt holds the index of the current grant cycle; the last allowed one ends the burst.
    assign w_burst_done = (r_cnt == CNT_LAST);
    assign w_yield      = r_yield;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_yield <= 1'b0;
        end else begin
            if (r_state == S_GRANT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_force_release) begin
                r_yield <= 1'b1;
            end else if (r_state == S_FETCH) begin
                r_yield <= 1'b0;
            end
        end
    end
`else
    assign w_burst_done = 1'b0;
    assign w_yield      = 1'b0;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_force_release = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (l_req) begin
                    w_state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!l_req) begin
                    w_state_next = S_RELEASE;
                end else if (w_burst_done) begin
                    w_state_next    = S_RELEASE;
                    w_force_release = 1'b1;
                end
            end
            S_RELEASE: w_state_next = S_FETCH;
            default:   w_state_next = S_FETCH;
        endcase
    end

    // During a yield window the loader request is ignored so one fetch can get through.
    assign w_accept = ~rst & (r_state == S_FETCH) & f_req & (~l_req | w_yield);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_f_valid <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_f_valid <= w_accept;
        end
    end

    assign l_gnt      = ~rst & (r_state == S_GRANT);
    assign f_flush    = ~rst & (r_state == S_RELEASE);
    assign f_stall    = rst | (r_state != S_FETCH) | (l_req & ~w_yield);
    assign f_valid    = r_f_valid;
    assign f_rdata    = mem_q;
    assign mem_rdaddr = f_addr;
    assign mem_wraddr = l_addr;
    assign mem_data   = l_data;
    assign mem_wren   = l_gnt & l_we;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a cycle model predicts every output into a queue and a
// negedge monitor compares. Honours IMEM_ARB_FAIR_EN with a burst limit of 4.
module tb_imem_arbiter;

    localparam int unsigned MAXB = 4;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [15:0] f_addr;
    logic [15:0] f_rdata;
    logic        f_valid;
    logic        f_stall;
    logic        f_flush;
    logic        l_req;
    logic        l_gnt;
    logic        l_we;
    logic [15:0] l_addr;
    logic [15:0] l_data;
    logic [15:0] mem_rdaddr;
    logic [15:0] mem_wraddr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;

    imem_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .rst        (rst),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_rdata    (f_rdata),
        .f_valid    (f_valid),
        .f_stall    (f_stall),
        .f_flush    (f_flush),
        .l_req      (l_req),
        .l_gnt      (l_gnt),
        .l_we       (l_we),
        .l_addr     (l_addr),
        .l_data     (l_data),
        .mem_rdaddr (mem_rdaddr),
        .mem_wraddr (mem_wraddr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at address a is 0xA000 + a, one-cycle read latency.
    always @(posedge clk) mem_q <= 16'hA000 + mem_rdaddr;

    typedef struct {
        logic        gnt;
        logic        stall;
        logic        flush;
        logic        wren;
        logic        valid;
        logic [15:0] rdata;
        logic [15:0] rdaddr;
        logic [15:0] wraddr;
        logic [15:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: who owns the port, and what is owed to fetch.
    bit          m_loader_owns = 1'b0;
    bit          m_flush_owed  = 1'b0;
    bit          m_yield_owed  = 1'b0;
    int          m_burst_len   = 0;
    bit          m_valid       = 1'b0;
    logic [15:0] m_word        = 16'h0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the predicted outputs for that cycle.
    task automatic step(input logic r, input logic fr, input logic [15:0] fa, input logic lr,
                        input logic lw, input logic [15:0] la, input logic [15:0] ld);
        exp_t e;
        bit   accept;
        @(posedge clk);
        #1;
        rst = r; f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_data = ld;
        e.rdaddr = fa;
        e.wraddr = la;
        e.wdata  = ld;
        e.rdata  = m_word;
        accept   = 1'b0;
        if (r) begin
            e.gnt = 0; e.stall = 1; e.flush = 0; e.wren = 0; e.valid = 0;
            m_loader_owns = 0; m_flush_owed = 0; m_yield_owed = 0;
        end else begin
            e.valid = m_valid;
            if (m_flush_owed) begin
                e.gnt = 0; e.stall = 1; e.flush = 1; e.wren = 0;
                m_flush_owed = 0;
            end else if (m_loader_owns) begin
                e.gnt = 1; e.stall = 1; e.flush = 0; e.wren = lw;
                m_burst_len++;
                if (!lr) begin
                    m_loader_owns = 0; m_flush_owed = 1;
                end
`ifdef IMEM_ARB_FAIR_EN
                else if (m_burst_len == MAXB) begin
                    m_loader_owns = 0; m_flush_owed = 1; m_yield_owed = 1;
                end
`endif
            end else begin
                e.gnt = 0; e.flush = 0; e.wren = 0;
                e.stall = lr && !m_yield_owed;
                accept  = fr && (!lr || m_yield_owed);
                m_yield_owed = 0;
                if (lr) begin
                    m_loader_owns = 1; m_burst_len = 0;
                end
            end
        end
        m_valid = accept;
        if (accept) m_word = 16'hA000 + fa;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("l_gnt",      {15'b0, l_gnt},    {15'b0, e.gnt});
                check("f_stall",    {15'b0, f_stall},  {15'b0, e.stall});
                check("f_flush",    {15'b0, f_flush},  {15'b0, e.flush});
                check("mem_wren",   {15'b0, mem_wren}, {15'b0, e.wren});
                check("f_valid",    {15'b0, f_valid},  {15'b0, e.valid});
                check("mem_rdaddr", mem_rdaddr, e.rdaddr);
                check("mem_wraddr", mem_wraddr, e.wraddr);
                check("mem_data",   mem_data,   e.wdata);
                if (e.valid && f_valid) check("f_rdata", f_rdata, e.rdata);
            end
        end
    end

    initial begin : stimulus
        int lreq_left;
        rst = 1'b1; f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_data = 0;
        step(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        step(1, 1, 16'h0, 1, 1, 16'h0, 16'h0);
        // Fetch only.
        for (int i = 0; i < 4; i++) step(0, 1, 16'(i), 0, 0, 16'h0, 16'h0);
        // Load burst of four writes; request one cycle ahead of the grant.
        step(0, 1, 16'h4, 1, 0, 16'h0010, 16'h1111);
        for (int i = 0; i < 4; i++) step(0, 1, 16'h4, 1, 1, 16'h0010 + 16'(i), 16'h1111 + 16'(i));
        for (int i = 0; i < 4; i++) step(0, 1, 16'h5 + 16'(i), 0, 0, 16'h0, 16'h0);
        // Contention followed by a reset during the second write.
        step(0, 1, 16'h20, 1, 0, 16'h0, 16'h0);
        step(0, 1, 16'h21, 1, 1, 16'h0030, 16'h2222);
        step(1, 1, 16'h22, 1, 1, 16'h0031, 16'h2223);
        step(0, 1, 16'h23, 0, 0, 16'h0, 16'h0);
        step(0, 1, 16'h24, 0, 0, 16'h0, 16'h0);
        // Write strobe with no grant.
        for (int i = 0; i < 3; i++) step(0, 1, 16'h30 + 16'(i), 0, 1, 16'h0040, 16'hDEAD);
        // Long request to exercise the burst limit when fairness is built in.
        for (int i = 0; i < 10; i++) step(0, 1, 16'h40 + 16'(i), 1, 1, 16'h50 + 16'(i), 16'(i));
        for (int i = 0; i < 3; i++) step(0, 1, 16'h60 + 16'(i), 0, 0, 16'h0, 16'h0);
        // Randomized traffic.
        lreq_left = 0;
        for (int i = 0; i < 800; i++) begin
            logic lr;
            lr = 1'b0;
            if (lreq_left > 0) begin
                lr = 1'b1;
                lreq_left--;
            end else if ($urandom % 6 == 0) begin
                lreq_left = $urandom_range(1, 12);
            end
            step(($urandom % 90) == 0, ($urandom % 4) != 0, 16'($urandom), lr,
                 ($urandom % 2) == 1, 16'($urandom), 16'($urandom));
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
